// File: rtl/serial_stream_feeder_pkg.sv
// Shared types and helpers for the serial stream feeder.
package serial_stream_feeder_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit that goes out first for a word of the given width and bit order.
  function automatic logic head_bit(input logic [31:0] word,
                                    input int unsigned width,
                                    input logic        msb_first);
    return msb_first ? word[5'(width - 1)] : word[0];
  endfunction

endpackage

// File: rtl/serial_stream_feeder_if.sv
// Parallel-word valid/ready handshake into the feeder.
interface serial_stream_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/serial_shift_reg.sv
// Loadable shift register; exposes the head bit it will present after the next edge.
module serial_shift_reg
  import serial_stream_feeder_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             head_nxt_o
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = data_i;
    end else if (shift_i) begin
      sh_d = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  assign head_nxt_o = head_bit(32'(sh_d), WIDTH, MSB_FIRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/serial_stream_feeder.sv
// Serializes handshaked parallel words into a gap-free one-bit stream for the detector.
module serial_stream_feeder
  import serial_stream_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_stream_feeder_if.slave   in_if,
  output logic                    ser_out,
  output logic                    ser_valid,
  output logic                    last_bit,
  output logic                    busy,
  output logic [CNT_W-1:0]        word_count
);

  localparam int unsigned BC_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             last_bit_q, last_bit_d;
  logic             busy_q, busy_d;
  logic             alive_q;
  logic             last_cyc_c;
  logic             accept_c;
  logic             shift_c;
  logic             head_nxt;

  // Ready is held low until the first edge after reset release.
  assign last_cyc_c      = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
  assign in_if.in_ready  = alive_q && ((state_q == ST_IDLE) || last_cyc_c);
  assign accept_c        = in_if.in_valid && in_if.in_ready;

  serial_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (accept_c),
    .shift_i    (shift_c),
    .data_i     (in_if.in_data),
    .head_nxt_o (head_nxt)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    shift_c     = 1'b0;
    ser_out_d   = IDLE_LEVEL;
    ser_valid_d = 1'b0;
    last_bit_d  = 1'b0;
    busy_d      = 1'b0;

    if (last_cyc_c) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    if (accept_c) begin
      state_d   = ST_SHIFT;
      bit_cnt_d = BC_W'(WIDTH - 1);
    end else if (state_q == ST_SHIFT) begin
      if (last_cyc_c) begin
        state_d = ST_IDLE;
      end else begin
        shift_c   = 1'b1;
        bit_cnt_d = bit_cnt_q - BC_W'(1);
      end
    end

    if (state_d == ST_SHIFT) begin
      ser_out_d   = head_nxt;
      ser_valid_d = 1'b1;
      busy_d      = 1'b1;
      last_bit_d  = (bit_cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
      busy_q      <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      last_bit_q  <= last_bit_d;
      busy_q      <= busy_d;
      alive_q     <= 1'b1;
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign last_bit   = last_bit_q;
  assign busy       = busy_q;
  assign word_count = word_cnt_q;

endmodule

// File: doc/serial_stream_feeder.md
Name: serial_stream_feeder

Overview:
- Upstream stage of the serial FSM detector: accepts parallel words over a valid/ready handshake and serializes them into the one-bit stream driven onto the detector's data_in.
- Supports back-to-back words with no idle bit between them, so the detector sees a continuous stream. Patterns that straddle word boundaries are therefore testable in hardware.
- Counts words and bits issued, for the scoreboard and for debug.

Parameters:
- WIDTH, 8, bits per parallel word (2..32)
- MSB_FIRST, 1, 1 = in_data[WIDTH-1] is sent first; 0 = in_data[0] first
- IDLE_LEVEL, 0, value driven on ser_out while no word is being shifted
- CNT_W, 16, width of the word_count output

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- in_valid  input  1  in_data holds a word to send
- in_ready  output  1  feeder can accept a word this cycle
- in_data  input  WIDTH  parallel word
- ser_out  output  1  serial bit, connects to the detector's data_in
- ser_valid  output  1  ser_out carries a real data bit this cycle
- last_bit  output  1  current ser_out bit is the final bit of its word
- busy  output  1  a word is being shifted
- word_count  output  CNT_W  number of words fully sent since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_out=IDLE_LEVEL; ser_valid=0, last_bit=0, busy=0, word_count=0; in_ready=0 while reset is held.
  - After release, in_ready=1 from the first clock edge.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load in_data into the shift register, set bit counter=WIDTH-1, go to SHIFT.
  - Otherwise stay in IDLE with ser_out=IDLE_LEVEL.
- SHIFT:
  - ser_valid=1; ser_out = current head bit (MSB or LSB per MSB_FIRST); busy=1.
  - Each cycle, shift one bit and decrement the bit counter.
  - last_bit=1 when the bit counter reaches 0.
- Latency: the first bit of a word appears on ser_out the cycle after the handshake. A word occupies exactly WIDTH consecutive cycles.
- Back-to-back:
  - In SHIFT, in_ready=1 only on the last_bit cycle.
  - If a handshake occurs on that cycle, the new word loads and its first bit follows immediately with no gap; state stays SHIFT.
  - Otherwise the state returns to IDLE.
- word_count increments on the clock edge ending every last_bit cycle, including wrap from 2^CNT_W-1 to 0.
- in_valid without in_ready: no effect. The source holds in_data stable; the feeder does not sample it.
- in_data changes mid-word: no effect; only the registered copy is shifted.
- Reset mid-word: the partial word is abandoned immediately (asynchronously); ser_out returns to IDLE_LEVEL; no further bits of that word are sent and word_count does not count it.
- All outputs are registered except in_ready, which is decoded from state and the bit counter.

Decomposition:
- Shared package:
  - state enum (IDLE, SHIFT)
  - default WIDTH and CNT_W constants
  - bit-order function returning the head bit for a given MSB_FIRST
- One natural sub-module: serial_shift_reg, a loadable WIDTH-bit shift register with a direction parameter and head-bit output. The FSM, counter and handshake stay in the top.

Test Plan:
- Reset release, in_valid=0 for 10 cycles -> in_ready=1, ser_valid=0, ser_out=0, word_count=0 throughout.
- Single word 8'hB4, MSB_FIRST=1 -> ser_out 1,0,1,1,0,1,0,0 on cycles 1..8 after handshake; last_bit only on cycle 8; word_count=1; back to IDLE.
- 8'hB4 then 8'h0F held valid, MSB_FIRST=1 -> 16 contiguous bits 10110100_00001111, ser_valid never drops, second handshake on first word's last_bit cycle, word_count=2.
- MSB_FIRST=0, word 8'h01 -> ser_out 1 on first bit cycle, then 0 x7.
- reset=0 asserted after 3 bits of 8'hFF -> ser_out=0, ser_valid=0, busy=0 immediately without waiting for a clock edge; word_count unchanged; a new word after release is sent in full.
- CNT_W=2, send 5 words -> word_count 1,2,3,0,1.
